// File: rtl/cmd_rx_pkg.sv
// Shared definitions for the command receive path.
// Widths and the serial bit period default live here so that cmd_rx, data_dec
// and any bench agree on codeword and field sizes. The FSM state encodings are
// 3-bit constants so they can also be probed from outside the receiver.
package cmd_rx_pkg;

   localparam int DATA_L  = 14;   // Hamming(14,10) codeword width
   localparam int CMD_L   = 4;    // command field width used by data_dec
   localparam int CLK_DIV = 16;   // default clk cycles per serial bit

   typedef logic [2:0] fsm_state_t;

   localparam fsm_state_t ST_IDLE  = 3'd0;
   localparam fsm_state_t ST_START = 3'd1;
   localparam fsm_state_t ST_DATA  = 3'd2;
   localparam fsm_state_t ST_STOP  = 3'd3;
   localparam fsm_state_t ST_BREAK = 3'd4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Reset value is 1 so an idle-high serial line does not look like a start bit
// while the flops fill after reset.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   d    asynchronous input
//   q    synchronized output (two clk of latency)
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/cmd_rx.sv
// Serial receiver for one Hamming(14,10) codeword per frame.
// Frame format: start bit (0), data_l data bits LSB first, stop bit (1); the
// line idles high. Bits are sampled mid-bit using a clk_div-per-bit counter.
// Frames with a low stop bit are flagged on frm_err and never forwarded.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   rx       asynchronous serial line, idle high
//   data     last good codeword, held until the next good frame
//   avl      one-cycle pulse, data updated this cycle
//   frm_err  one-cycle pulse, stop bit sampled low, frame discarded
//   busy     high whenever the receiver is not idle
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for rx_s to fall
// ST_START | counting to mid start bit; high there means a glitch
// ST_DATA  | sampling data bits at each full bit period
// ST_STOP  | sampling stop bit; high forwards the word, low flags frm_err
// ST_BREAK | line stuck low after a framing error; wait for it to go high
module cmd_rx
   import cmd_rx_pkg::*;
#(
   parameter int data_l  = DATA_L,
   parameter int clk_div = CLK_DIV
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx,
   output logic [data_l-1:0] data,
   output logic              avl,
   output logic              frm_err,
   output logic              busy
);

   localparam int bcnt_w = $clog2(clk_div);
   localparam int idx_w  = $clog2(data_l + 1);

   localparam logic [bcnt_w-1:0] half_tc  = bcnt_w'(clk_div / 2 - 1);
   localparam logic [bcnt_w-1:0] full_tc  = bcnt_w'(clk_div - 1);
   localparam logic [idx_w-1:0]  last_idx = idx_w'(data_l - 1);

   fsm_state_t        state;
   logic [bcnt_w-1:0] bcnt;
   logic [idx_w-1:0]  idx;
   logic [data_l-1:0] shreg;
   logic              rx_s;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         bcnt    <= '0;
         idx     <= '0;
         shreg   <= '0;
         data    <= '0;
         avl     <= 1'b0;
         frm_err <= 1'b0;
      end else begin
         avl     <= 1'b0;
         frm_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!rx_s) begin
                  state <= ST_START;
                  bcnt  <= '0;
               end
            end
            ST_START: begin
               if (bcnt == half_tc) begin
                  // Still low at mid start bit: a real frame. From here on the
                  // counter is aligned to bit centres.
                  if (!rx_s) begin
                     state <= ST_DATA;
                     bcnt  <= '0;
                     idx   <= '0;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  bcnt <= bcnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (bcnt == full_tc) begin
                  shreg[idx] <= rx_s;
                  idx        <= idx + 1'b1;
                  bcnt       <= '0;
                  if (idx == last_idx) begin
                     state <= ST_STOP;
                  end
               end else begin
                  bcnt <= bcnt + 1'b1;
               end
            end
            ST_STOP: begin
               if (bcnt == full_tc) begin
                  if (rx_s) begin
                     data  <= shreg;
                     avl   <= 1'b1;
                     state <= ST_IDLE;
                  end else begin
                     frm_err <= 1'b1;
                     state   <= ST_BREAK;
                  end
               end else begin
                  bcnt <= bcnt + 1'b1;
               end
            end
            ST_BREAK: begin
               // Hold here so a line stuck low yields a single frm_err rather
               // than one per bogus frame.
               if (rx_s) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_rx.sv
module tb_cmd_rx;

   localparam int DL = 14;
   localparam int CD = 16;

   logic          clk;
   logic          rst;
   logic          rx;
   logic [DL-1:0] data;
   logic          avl;
   logic          frm_err;
   logic          busy;

   cmd_rx #(.data_l(DL), .clk_div(CD)) dut (
      .clk     (clk),
      .rst     (rst),
      .rx      (rx),
      .data    (data),
      .avl     (avl),
      .frm_err (frm_err),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge clk) cyc++;

   // Event monitor: counts pulses, records delivered words, flags pulse-rule violations.
   int          n_avl = 0;
   int          n_err = 0;
   int          n_viol = 0;
   int          last_avl_cyc = 0;
   logic        prev_avl = 1'b0;
   logic        prev_err = 1'b0;
   logic [DL-1:0] got_q[$];

   always @(negedge clk) begin
      if (!rst) begin
         if (avl) begin
            n_avl++;
            last_avl_cyc = cyc;
            got_q.push_back(data);
         end
         if (frm_err) n_err++;
         if (avl && frm_err) n_viol++;
         if (avl && prev_avl) n_viol++;
         if (frm_err && prev_err) n_viol++;
      end
      prev_avl = avl;
      prev_err = frm_err;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Drive one frame; must be called at a negedge, returns at a negedge with rx=1.
   task automatic send_frame(input logic [DL-1:0] w, input logic stop_bit, output int t0);
      rx = 1'b0;
      t0 = cyc;
      repeat (CD) @(negedge clk);
      for (int i = 0; i < DL; i++) begin
         rx = w[i];
         repeat (CD) @(negedge clk);
      end
      rx = stop_bit;
      repeat (CD) @(negedge clk);
      rx = 1'b1;
   endtask

   function automatic logic [13:0] ham_enc(input logic [9:0] p);
      logic [13:0] c;
      logic        par;
      int          j;
      c = '0;
      j = 0;
      for (int pos = 1; pos <= 14; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            c[pos-1] = p[j];
            j++;
         end
      end
      for (int k = 0; k < 4; k++) begin
         par = 1'b0;
         for (int pos = 1; pos <= 14; pos++)
            if (((pos >> k) & 1) == 1 && pos != (1 << k)) par ^= c[pos-1];
         c[(1 << k) - 1] = par;
      end
      return c;
   endfunction

   function automatic logic [9:0] ham_dec(input logic [13:0] cin);
      logic [13:0] c;
      logic [9:0]  p;
      int          syn;
      int          j;
      c   = cin;
      syn = 0;
      for (int pos = 1; pos <= 14; pos++) if (c[pos-1]) syn ^= pos;
      if (syn >= 1 && syn <= 14) c[syn-1] = ~c[syn-1];
      p = '0;
      j = 0;
      for (int pos = 1; pos <= 14; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            p[j] = c[pos-1];
            j++;
         end
      end
      return p;
   endfunction

   typedef struct {
      logic [DL-1:0] word;
      logic          stop_bit;
      int            gap;
      int            exp_avl;
      int            exp_err;
      logic [DL-1:0] exp_data;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int            t0, a0, e0, lat;
      logic [DL-1:0] exp_data;
      logic [DL-1:0] w;
      logic [DL-1:0] sent[16];
      logic [9:0]    pl;
      logic          bad;
      int            gap;

      vecs[0] = '{14'h2A5B, 1'b1, 5, 1, 0, 14'h2A5B};
      vecs[1] = '{14'h1234, 1'b0, 6, 0, 1, 14'h2A5B};
      vecs[2] = '{14'h0F0F, 1'b1, 3, 1, 0, 14'h0F0F};
      vecs[3] = '{14'h3C3C, 1'b1, 0, 1, 0, 14'h3C3C};
      vecs[4] = '{14'h0000, 1'b1, 2, 1, 0, 14'h0000};

      // Reset
      rst = 1'b1;
      rx  = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_data", 32'(data), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      chk("idle_avl_cnt", 32'(n_avl), 32'h0);
      chk("idle_err_cnt", 32'(n_err), 32'h0);
      chk("idle_data", 32'(data), 32'h0);
      chk("idle_busy", 32'(busy), 32'h0);

      // Directed frame table
      for (int v = 0; v < 5; v++) begin
         a0 = n_avl;
         e0 = n_err;
         send_frame(vecs[v].word, vecs[v].stop_bit, t0);
         repeat (vecs[v].gap) @(negedge clk);
         chk($sformatf("tbl%0d_avl", v), 32'(n_avl - a0), 32'(vecs[v].exp_avl));
         chk($sformatf("tbl%0d_err", v), 32'(n_err - e0), 32'(vecs[v].exp_err));
         chk($sformatf("tbl%0d_data", v), 32'(data), 32'(vecs[v].exp_data));
         if (vecs[v].exp_avl == 1) begin
            lat = last_avl_cyc - t0;
            chk($sformatf("tbl%0d_latency_%0d", v, lat), 32'(lat >= 249 && lat <= 251), 32'h1);
         end
      end
      exp_data = 14'h0000;

      // Hamming codeword through the receiver and decoded to fields
      repeat (3) @(negedge clk);
      pl = {2'd1, 4'd5, 4'd5};
      send_frame(ham_enc(pl), 1'b1, t0);
      repeat (3) @(negedge clk);
      chk("ham_data", 32'(data), 32'(ham_enc(pl)));
      chk("ham_mode", 32'(ham_dec(data) >> 8), 32'd1);
      chk("ham_spd", 32'((ham_dec(data) >> 4) & 10'hF), 32'd5);
      chk("ham_dir", 32'(ham_dec(data) & 10'hF), 32'd5);
      exp_data = ham_enc(pl);

      // Glitch on the line
      a0 = n_avl;
      e0 = n_err;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      chk("glitch_busy", 32'(busy), 32'h1);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      chk("glitch_avl", 32'(n_avl - a0), 32'h0);
      chk("glitch_err", 32'(n_err - e0), 32'h0);
      chk("glitch_busy_after", 32'(busy), 32'h0);
      chk("glitch_data", 32'(data), 32'(exp_data));

      // Back-to-back frames with no idle gap
      got_q.delete();
      a0 = n_avl;
      for (int i = 0; i < 16; i++) begin
         sent[i] = ham_enc(10'(i));
         send_frame(sent[i], 1'b1, t0);
      end
      repeat (4) @(negedge clk);
      chk("b2b_count", 32'(n_avl - a0), 32'd16);
      for (int i = 0; i < 16; i++) begin
         if (got_q.size() > 0) chk($sformatf("b2b_word%0d", i), 32'(got_q.pop_front()), 32'(sent[i]));
         else chk($sformatf("b2b_missing%0d", i), 32'h0, 32'h1);
      end
      exp_data = sent[15];

      // Line break: one frm_err only
      a0 = n_avl;
      e0 = n_err;
      rx = 1'b0;
      repeat (400) @(negedge clk);
      rx = 1'b1;
      repeat (10) @(negedge clk);
      chk("break_err", 32'(n_err - e0), 32'd1);
      chk("break_avl", 32'(n_avl - a0), 32'd0);
      chk("break_data", 32'(data), 32'(exp_data));
      chk("break_busy", 32'(busy), 32'h0);

      // Reset during data bit 7 of 14'h3FFF
      a0 = n_avl;
      e0 = n_err;
      rx = 1'b0;
      repeat (CD) @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         rx = 1'b1;
         repeat (CD) @(negedge clk);
      end
      rx = 1'b1;
      repeat (CD / 2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("midrst_data", 32'(data), 32'h0);
      rst = 1'b0;
      repeat (CD * 8) @(negedge clk);
      chk("midrst_avl", 32'(n_avl - a0), 32'h0);
      chk("midrst_err", 32'(n_err - e0), 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_data_after", 32'(data), 32'h0);
      send_frame(14'h0001, 1'b1, t0);
      repeat (2) @(negedge clk);
      chk("midrst_next_avl", 32'(n_avl - a0), 32'h1);
      chk("midrst_next_data", 32'(data), 32'h0001);
      exp_data = 14'h0001;

      // Random frames against the model: data tracks the last good word,
      // each good frame gives one avl, each bad stop gives one frm_err.
      for (int r = 0; r < 40; r++) begin
         w   = DL'($urandom_range(0, (1 << DL) - 1));
         bad = ($urandom_range(0, 4) == 0);
         gap = bad ? int'($urandom_range(3, 12)) : int'($urandom_range(0, 6));
         a0  = n_avl;
         e0  = n_err;
         send_frame(w, ~bad, t0);
         repeat (gap) @(negedge clk);
         if (!bad) exp_data = w;
         chk($sformatf("rnd%0d_avl", r), 32'(n_avl - a0), bad ? 32'd0 : 32'd1);
         chk($sformatf("rnd%0d_err", r), 32'(n_err - e0), bad ? 32'd1 : 32'd0);
         chk($sformatf("rnd%0d_data", r), 32'(data), 32'(exp_data));
      end

      repeat (20) @(negedge clk);
      chk("pulse_rules", 32'(n_viol), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
